// File: rtl/divisor_iterativo_if.sv
// divisor_iterativo_if: request/response bundle between the execute stage and the iterative divider.
interface divisor_iterativo_if #(parameter int N = 32);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         div_zero;
  modport master (output start, op, dividend, divisor, input busy, done, result, div_zero);
  modport slave  (input start, op, dividend, divisor, output busy, done, result, div_zero);
endinterface

// File: rtl/divisor_iterativo.sv
// divisor_iterativo: fixed-latency restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
module divisor_iterativo #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input logic clk,
  input logic rst,
  divisor_iterativo_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PREP, DIV, FIX} state_t;
  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, bm_q, bm_d, r_q, r_d, q_q, q_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         qs_q, qs_d, rs_q, rs_d, dz_q, dz_d, done_q, done_d;
  logic         sgn, ovf, dz;
  logic [N:0]   t;
  logic [N-1:0] am, quo, rem;
  // The partial remainder always stays below |divisor|, so N bits hold it; t[N] is the borrow.
  always_comb begin
    sgn     = ~op_q[0];
    am      = (sgn && a_q[N-1]) ? -a_q : a_q;
    t       = {r_q, q_q[N-1]} - {1'b0, bm_q};
    dz      = b_q == '0;
    ovf     = sgn && a_q == {1'b1, {(N-1){1'b0}}} && &b_q;
    quo     = dz ? '1 : ovf ? a_q : qs_q ? -q_q : q_q;
    rem     = dz ? a_q : ovf ? '0 : rs_q ? -r_q : r_q;
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    bm_d    = bm_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    res_d   = res_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = PREP;
        op_d    = bus.op;
        a_d     = bus.dividend;
        b_d     = bus.divisor;
      end
      PREP: begin
        bm_d    = (sgn && b_q[N-1]) ? -b_q : b_q;
        qs_d    = sgn && (a_q[N-1] ^ b_q[N-1]);
        rs_d    = sgn && a_q[N-1];
        r_d     = '0;
        q_d     = am;
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        r_d     = t[N] ? {r_q[N-2:0], q_q[N-1]} : t[N-1:0];
        q_d     = {q_q[N-2:0], ~t[N]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(N - 1)) ? FIX : DIV;
      end
      FIX: begin
        res_d   = op_q[1] ? rem : quo;
        dz_d    = dz;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bm_q    <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bm_q    <= bm_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy     = state_q != IDLE;
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_divisor_iterativo.sv
// tb_divisor_iterativo: directed table, handshake/reset sequences and random ops against an arithmetic model.
module tb_divisor_iterativo;
  localparam int N = 32;
  localparam int LAT = N + 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  divisor_iterativo_if #(.N(N)) bus ();
  divisor_iterativo #(.N(N), .CW(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic         dz;
  } vec_t;
  vec_t tbl [12];
  logic [N-1:0] res, exp_res;
  logic dz, seen;
  logic [N:0] m;
  int lat, bsy;
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [N:0] model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] q, r;
    if (b == '0) begin
      q = {N{1'b1}};
      r = a;
      return {1'b1, op[1] ? r : q};
    end
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, op[1] ? r : q};
  endfunction
  task automatic wait_done(inout int k, output int busy_cnt);
    busy_cnt = k;
    while (!bus.done && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.busy) busy_cnt++;
    end
  endtask
  task automatic run(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                     output logic [N-1:0] r, output logic z, output int k, output int busy_cnt);
    bus.start = 1'b1;
    bus.op = op;
    bus.dividend = a;
    bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 0;
    busy_cnt = 0;
    if (bus.busy) busy_cnt++;
    while (!bus.done && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.busy && !bus.done) busy_cnt++;
    end
    r = bus.result;
    z = bus.div_zero;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.dividend = '0;
    bus.divisor = '0;
    tbl[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         1'b0};
    tbl[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          1'b0};
    tbl[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    tbl[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    tbl[4]  = '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
    tbl[5]  = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
    tbl[6]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    tbl[7]  = '{2'd3, 32'd5,          32'd0,          32'd5,          1'b1};
    tbl[8]  = '{2'd0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1};
    tbl[9]  = '{2'd2, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1};
    tbl[10] = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
    tbl[11] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_result", bus.result, 0);
    check("reset_dz", 32'(bus.div_zero), 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run(tbl[i].op, tbl[i].a, tbl[i].b, res, dz, lat, bsy);
      check($sformatf("tbl%0d_result", i), res, tbl[i].res);
      check($sformatf("tbl%0d_dz", i), 32'(dz), 32'(tbl[i].dz));
      check($sformatf("tbl%0d_latency", i), lat, LAT);
      check($sformatf("tbl%0d_busy_cycles", i), bsy, LAT);
      check($sformatf("tbl%0d_busy_at_done", i), 32'(bus.busy), 0);
    end
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(bus.done), 0);
    check("result_held", bus.result, 32'd0);
    // Handshake: a start pulse mid-operation must not disturb the first op.
    bus.start = 1'b1;
    bus.op = 2'd1;
    bus.dividend = 32'd100;
    bus.divisor = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.dividend = 32'd1000;
    bus.divisor = 32'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat++;
    wait_done(lat, bsy);
    check("ignored_start_latency", lat, LAT);
    check("ignored_start_result", bus.result, 32'd14);
    check("ignored_start_dz", 32'(bus.div_zero), 0);
    check("done_before_b2b", 32'(bus.done), 1);
    run(2'd0, 32'hFFFF_FFF9, 32'd2, res, dz, lat, bsy);
    check("b2b_latency", lat, LAT);
    check("b2b_result", res, 32'hFFFF_FFFD);
    // Reset after ten iterations aborts the op without a done pulse.
    bus.start = 1'b1;
    bus.op = 2'd1;
    bus.dividend = 32'd1000;
    bus.divisor = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_result", bus.result, 0);
    check("abort_dz", 32'(bus.div_zero), 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 0);
    run(2'd1, 32'd9, 32'd3, res, dz, lat, bsy);
    check("after_abort_result", res, 32'd3);
    check("after_abort_latency", lat, LAT);
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      logic [N-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      m = model(op, a, b);
      exp_res = m[N-1:0];
      run(op, a, b, res, dz, lat, bsy);
      check($sformatf("rnd%0d_op%0d_%h_%h_result", i, op, a, b), res, exp_res);
      check($sformatf("rnd%0d_dz", i), 32'(dz), 32'(m[N]));
      check($sformatf("rnd%0d_latency", i), lat, LAT);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/divisor_iterativo.md
Name: divisor_iterativo

Overview:
- Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU group of the execute stage.
- Sits downstream of the ALU operand path and consumes one (N+1)-bit subtract-with-borrow per cycle: a restoring, shift-subtract datapath, one quotient bit per clock.
- Stalls the pipeline via busy and delivers a single result word with a one-cycle done pulse.
- Fixed latency for every operand combination, so hazard logic needs no data-dependent timing.

Parameters:
- N, 32, operand/result width in bits (N >= 4).
- CW, 6, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
- dividend  input  N  rs1 value; captured on the accepting edge.
- divisor  input  N  rs2 value; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result is valid.
- result  output  N  quotient or remainder as selected by op; held until the next accepted start.
- div_zero  output  1  divisor was zero for the op that produced result; held with result.

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over everything, including mid-operation.
  - Effect: state=IDLE, busy=0, done=0, result=0, div_zero=0, all internal registers=0.
  - An aborted operation produces no done pulse.
- States: IDLE, PREP, DIV, FIX.
- IDLE:
  - On start=1, go to PREP.
  - Same edge: capture op, dividend, divisor; set busy=1.
  - start=0 keeps IDLE. done is always cleared on the edge after it rose.
- PREP:
  - Compute magnitudes: for signed ops, negate negative operands (two's complement).
  - Record quotient sign (sign(dividend) XOR sign(divisor)) and remainder sign (sign(dividend)).
  - Load remainder register R (N+1 bits) = 0, quotient register Q = |dividend|, counter = 0.
  - Go to DIV.
- DIV, one iteration per edge, N iterations:
  - T = {R[N-1:0], Q[N-1]} - {1'b0, |divisor|}, computed (N+1) bits wide.
  - If there is no borrow (T >= 0): R = T and the shifted-in quotient bit is 1.
  - Otherwise R = {R[N-1:0], Q[N-1]} and the bit is 0.
  - Q = {Q[N-2:0], bit}; counter += 1.
  - After iteration N (counter reaches N), go to FIX.
- FIX:
  - Apply sign fixups: negate Q if the quotient sign is set; negate R[N-1:0] if the remainder sign is set.
  - Apply special cases, which override the above:
    - Divisor == 0: quotient = all ones; remainder = original dividend; div_zero=1.
    - Signed overflow, DIV/REM with dividend = 2^(N-1) and divisor = all ones: quotient = dividend, remainder = 0.
  - Write result per op; set done=1, busy=0; go to IDLE.
  - Zero-divisor and overflow cases still run the full N iterations (fixed latency).
- Latency:
  - Start is sampled at edge E.
  - busy is high from after E until after E+N+2.
  - done is high for exactly the cycle after E+N+2. For N=32 that is edge E+34.
- Handshake rules:
  - start while busy=1 is ignored; operands are not re-captured.
  - start=1 in the cycle done=1 (state IDLE) is accepted: back-to-back ops lose no cycles.
  - result and div_zero change only on the FIX edge or on reset.
- Arithmetic:
  - All unsigned magnitudes are N bits. The intermediate remainder is N+1 bits so the compare cannot overflow.
  - Negation of 2^(N-1) wraps to itself, which is correct for the overflow case.

Test Plan:
- DIVU 100/7, N=32 -> done exactly 34 edges after start, result=14, busy high for 34 cycles, div_zero=0; REMU same operands -> result=2.
- DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIV 7/0xFFFFFFFE (-2) -> 0xFFFFFFFD; REM -> 1.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, div_zero=1; REMU 5/0 -> 5; DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF; REM -> 0xFFFFFFFB; latency still 34.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; div_zero=0.
- Handshake: pulse start with new operands while busy -> ignored, first result unchanged. Then assert start during the done cycle -> second op accepted, its done exactly 34 edges later.
- Reset mid-operation at iteration 10 -> next cycle busy=0, done=0, result=0; no done pulse follows; a fresh DIVU 9/3 then returns 3.
